// File: rtl/dct8_rot_sched_if.sv
// Handshake/bus bundle between the DCT8 rotation sequencer (master) and its datapath/memory (slave).
// With DCT8_SCHED_HOLD_EN defined, the bundle also carries the stall input "hold".
interface dct8_rot_sched_if #(
  parameter int ADDR_W = 3
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [3:0]        angle_idx;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [ADDR_W-1:0] wr_addr_b;
  logic [1:0]        stage;
`ifdef DCT8_SCHED_HOLD_EN
  logic              hold;

  modport master (
    input  start, hold,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, angle_idx,
           wr_en, wr_addr_a, wr_addr_b, stage
  );
  modport slave (
    output start, hold,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, angle_idx,
           wr_en, wr_addr_a, wr_addr_b, stage
  );
`else
  modport master (
    input  start,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, angle_idx,
           wr_en, wr_addr_a, wr_addr_b, stage
  );
  modport slave (
    output start,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, angle_idx,
           wr_en, wr_addr_a, wr_addr_b, stage
  );
`endif
endinterface

// File: rtl/dct8_rot_sched.sv
// Stage sequencer for the memory-based DCT8 rotation datapath: issues operand-pair reads, delays them for write-back.
// Optional feature macro DCT8_SCHED_HOLD_EN adds a "hold" stall input that freezes the run in ISSUE/DRAIN.
module dct8_rot_sched #(
  parameter int ADDR_W     = 3,
  parameter int NUM_STAGES = 3,
  parameter int PIPE_LAT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dct8_rot_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
  } dl_t;

  state_t            state, state_nx;
  logic [1:0]        stage_q, stage_nx;
  logic [1:0]        pair_q, pair_nx;
  logic              issue;
  logic              rd_en_q, rd_en_nx;
  logic [ADDR_W-1:0] rd_a_q, rd_a_nx, rd_b_q, rd_b_nx;
  logic [3:0]        angle_q, angle_nx;
  logic              busy_q, done_q;
  logic              drained;
  logic              frz;
  dl_t               dl [PIPE_LAT];

`ifdef DCT8_SCHED_HOLD_EN
  assign frz = bus.hold && (state == ISSUE || state == DRAIN);
`else
  assign frz = 1'b0;
`endif

  // Stage 3 reuses the stage 0 mirror pairing.
  function automatic logic [2*ADDR_W-1:0] pair_addr(input logic [1:0] s, input logic [1:0] p);
    logic [2:0] a, b;
    case (s)
      2'd1:    begin a = {p[1], 1'b0, p[0]}; b = {p[1], 1'b1, ~p[0]}; end
      2'd2:    begin a = {p, 1'b0};          b = {p, 1'b1};          end
      default: begin a = {1'b0, p};          b = {1'b1, ~p};         end
    endcase
    return {ADDR_W'(a), ADDR_W'(b)};
  endfunction

  // The stage is finished when its last pair sits at the delay-line output with nothing behind it.
  always_comb begin
    drained = dl[PIPE_LAT-1].vld;
    for (int i = 0; i < PIPE_LAT-1; i++) begin
      if (dl[i].vld) drained = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    stage_nx = stage_q;
    pair_nx  = pair_q;
    issue    = 1'b0;
    rd_en_nx = 1'b0;
    rd_a_nx  = '0;
    rd_b_nx  = '0;
    angle_nx = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = ISSUE;
          stage_nx = 2'd0;
          pair_nx  = 2'd0;
          issue    = 1'b1;
        end
      end
      ISSUE: begin
        if (pair_q == 2'd3) begin
          state_nx = DRAIN;
        end else begin
          pair_nx = pair_q + 2'd1;
          issue   = 1'b1;
        end
      end
      DRAIN: begin
        if (drained) begin
          if (stage_q == 2'(NUM_STAGES-1)) begin
            state_nx = DONE;
          end else begin
            state_nx = ISSUE;
            stage_nx = stage_q + 2'd1;
            pair_nx  = 2'd0;
            issue    = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (issue) begin
      rd_en_nx             = 1'b1;
      {rd_a_nx, rd_b_nx}   = pair_addr(stage_nx, pair_nx);
      angle_nx             = {stage_nx, pair_nx};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      stage_q <= '0;
      pair_q  <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      angle_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) dl[i] <= '0;
    end else if (!frz) begin
      state   <= state_nx;
      stage_q <= stage_nx;
      pair_q  <= pair_nx;
      rd_en_q <= rd_en_nx;
      rd_a_q  <= rd_a_nx;
      rd_b_q  <= rd_b_nx;
      angle_q <= angle_nx;
      busy_q  <= (state_nx == ISSUE) || (state_nx == DRAIN);
      done_q  <= (state_nx == DONE);
      dl[0]   <= '{vld: rd_en_q, a: rd_a_q, b: rd_b_q};
      for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.rd_en     = rd_en_q && !frz;
  assign bus.rd_addr_a = frz ? '0 : rd_a_q;
  assign bus.rd_addr_b = frz ? '0 : rd_b_q;
  assign bus.angle_idx = frz ? '0 : angle_q;
  assign bus.wr_en     = dl[PIPE_LAT-1].vld && !frz;
  assign bus.wr_addr_a = frz ? '0 : dl[PIPE_LAT-1].a;
  assign bus.wr_addr_b = frz ? '0 : dl[PIPE_LAT-1].b;

endmodule
